// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters, with a
// per-character watchdog that aborts a character the transmitter never completes.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_parity,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             req_error,
    output logic                           send_request,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           parity_enable,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           arb_busy
);

    localparam int GW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_r;
    logic [GW-1:0]          last_grant_r;
    logic [WD_W-1:0]        wd_r;
    logic                   done_seen_r;

    logic                   pick_found_s;
    logic [GW-1:0]          pick_idx_s;
    logic [DATA_BITS-1:0]   pick_data_s;
    logic                   timeout_s;
    logic [WD_W-1:0]        wd_inc_s;
    logic [NUM_REQ-1:0]     one_hot_base_s;

    // Rotating-priority search starting just above the most recent grantee.
    always_comb begin
        int            sum;
        int            idx;
        logic [GW-1:0] cand;
        logic          hit;
        pick_found_s = 1'b0;
        pick_idx_s   = {GW{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum          = int'(last_grant_r) + k;
            idx          = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
            cand         = GW'(idx);
            hit          = !pick_found_s && req_valid[cand];
            pick_idx_s   = hit ? cand : pick_idx_s;
            pick_found_s = pick_found_s | hit;
        end
    end

    // Winner's character slice and watchdog helpers.
    always_comb begin
        pick_data_s    = req_data[int'(pick_idx_s)*DATA_BITS +: DATA_BITS];
        timeout_s      = (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
        wd_inc_s       = (wd_r == WD_W'(TIMEOUT_CYCLES)) ? wd_r : (wd_r + WD_W'(1));
        one_hot_base_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
    end

    // Arbitration FSM with registered strobes, capture registers and watchdog.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GW'(NUM_REQ - 1);
            wd_r          <= {WD_W{1'b0}};
            done_seen_r   <= 1'b0;
            send_request  <= 1'b0;
            req_ack       <= {NUM_REQ{1'b0}};
            req_done      <= {NUM_REQ{1'b0}};
            req_error     <= {NUM_REQ{1'b0}};
            tx_data       <= {DATA_BITS{1'b0}};
            parity_enable <= 1'b0;
            grant_id      <= {GW{1'b0}};
            arb_busy      <= 1'b0;
        end else begin
            send_request <= 1'b0;
            req_ack      <= {NUM_REQ{1'b0}};
            req_done     <= {NUM_REQ{1'b0}};
            req_error    <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r       <= ST_ISSUE;
                        tx_data       <= pick_data_s;
                        parity_enable <= req_parity[pick_idx_s];
                        grant_id      <= pick_idx_s;
                        last_grant_r  <= pick_idx_s;
                        send_request  <= 1'b1;
                        req_ack       <= one_hot_base_s << pick_idx_s;
                        wd_r          <= {WD_W{1'b0}};
                        done_seen_r   <= 1'b0;
                        arb_busy      <= 1'b1;
                    end else begin
                        arb_busy      <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT_BUSY;
                end
                // An early tx_done is remembered so WAIT_DONE can retire it at once.
                ST_WAIT_BUSY: begin
                    wd_r <= wd_inc_s;
                    if (tx_done) begin
                        done_seen_r <= 1'b1;
                        state_r     <= ST_WAIT_DONE;
                    end else if (timeout_s) begin
                        req_error   <= one_hot_base_s << grant_id;
                        state_r     <= ST_IDLE;
                        arb_busy    <= 1'b0;
                    end else if (tx_busy) begin
                        state_r     <= ST_WAIT_DONE;
                    end else begin
                        state_r     <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    wd_r <= wd_inc_s;
                    if (tx_done || done_seen_r) begin
                        req_done    <= one_hot_base_s << grant_id;
                        done_seen_r <= 1'b0;
                        state_r     <= ST_IDLE;
                        arb_busy    <= 1'b0;
                    end else if (timeout_s) begin
                        req_error   <= one_hot_base_s << grant_id;
                        state_r     <= ST_IDLE;
                        arb_busy    <= 1'b0;
                    end else begin
                        state_r     <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter: DATA_BITS, default 8, character width; matches the uart_tx it drives.
REQ-003 Parameter: TIMEOUT_CYCLES, default 65535, watchdog limit in clk cycles per character (>=16).
REQ-004 Reset and clock: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-low reset; sampled 0 on a rising edge resets the block.
REQ-007 req_valid  input  NUM_REQ  bit i: requester i holds a character pending.
REQ-008 req_data  input  NUM_REQ*DATA_BITS  slice i = bits [i*DATA_BITS +: DATA_BITS], character of requester i.
REQ-009 req_parity  input  NUM_REQ  bit i: requester i wants the odd-parity bit.
REQ-010 req_ack  output  NUM_REQ  one-cycle pulse: character of requester i captured.
REQ-011 req_done  output  NUM_REQ  one-cycle pulse: character of requester i fully sent.
REQ-012 req_error  output  NUM_REQ  one-cycle pulse: character of requester i aborted by watchdog.
REQ-013 send_request  output  1  to uart_tx; one-cycle start strobe.
REQ-014 tx_data  output  DATA_BITS  to uart_tx; captured character, stable from ISSUE through WAIT_DONE.
REQ-015 parity_enable  output  1  to uart_tx; captured parity select, stable with tx_data.
REQ-016 tx_busy  input  1  from uart_tx.
REQ-017 tx_done  input  1  from uart_tx; one-cycle completion pulse.
REQ-018 grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grantee.
REQ-019 arb_busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-021 IDLE with any req_valid high: round-robin pick, first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap.
REQ-022 At that edge: capture req_data/req_parity of winner into tx_data/parity_enable; set grant_id and last_grant; next state ISSUE.
REQ-023 At that edge: req_ack[winner]=1 and send_request=1 for exactly the ISSUE cycle; both deassert on the following edge.
REQ-024 ISSUE -> WAIT_BUSY unconditionally after one cycle.
REQ-025 WAIT_BUSY -> WAIT_DONE when tx_busy=1; WAIT_BUSY also exits to WAIT_DONE if tx_done=1 is seen first.
REQ-026 WAIT_DONE, tx_done=1 -> IDLE; req_done[grant_id]=1 for one cycle.
REQ-027 Watchdog: counter cleared on entry to ISSUE, increments in WAIT_BUSY/WAIT_DONE, saturates; width $clog2(TIMEOUT_CYCLES+1).
REQ-028 Counter reaching TIMEOUT_CYCLES before tx_done -> IDLE; req_error[grant_id]=1 for one cycle; no req_done.
REQ-029 tx_done and timeout on the same edge: tx_done wins; req_done only.
REQ-030 req_valid is sampled only in IDLE; deassertion before ack means no grant; changes after ack are ignored.
REQ-031 Requester i must drop req_valid on the cycle after req_ack; if still high in IDLE, it re-enters arbitration at lowest priority.
REQ-032 No back-to-back issue: minimum one IDLE cycle between req_done/req_error and the next send_request.
REQ-033 At most one bit of req_ack, req_done, req_error is set in any cycle.

Reset
REQ-034 reset=0 at an edge: state IDLE, send_request=0, req_ack/req_done/req_error=0, tx_data=0, parity_enable=0, arb_busy=0, grant_id=0, watchdog=0.
REQ-035 Reset sets last_grant=NUM_REQ-1, so requester 0 has top priority first.
REQ-036 Reset mid-character aborts silently with no req_done/req_error; the uart_tx is reset by the same signal at system level.

Verification
REQ-037 Single: after reset, req_valid=4'b0100, data 0x55, parity 1 -> next edge: send_request=1, req_ack=4'b0100, tx_data=0x55, parity_enable=1, grant_id=2; req_done=4'b0100 one cycle after tx_done.
REQ-038 Round-robin: req_valid=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0, with one character on the line at a time.
REQ-039 Fairness wrap: last grant 3, req_valid=4'b1001 -> grant 0, then 3.
REQ-040 Watchdog: TIMEOUT_CYCLES=20, tx_busy/tx_done tied 0 -> req_error pulse exactly 20 cycles after leaving ISSUE; next request grants normally.
REQ-041 Collision: tx_done on the same edge the counter hits limit -> req_done only, req_error stays 0.
REQ-042 Reset in WAIT_DONE -> all outputs at reset values next edge; no done/error pulse; first grant after reset goes to requester 0 if valid.
